// File: rtl/rvi_bj_ex_pipe.sv
// Branch/jump execute unit: two-stage resolve pipe with a redirect FSM
// and saturating retire/mispredict counters.
module rvi_bj_ex_pipe #(
  parameter int RV64  = 0,
  parameter int C_EXT = 1,
  parameter int CNT_W = 16,
  localparam int XLEN = 32 * (RV64 + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_vld,
  output logic            in_rdy,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] s1,
  input  logic [XLEN-1:0] s2,
  input  logic [XLEN-1:0] offset,
  input  logic [2:0]      op,
  input  logic            unsigned_flg,
  input  logic            rvc,
  input  logic            pred_taken,
  input  logic [XLEN-1:0] pred_tgt,
  output logic            out_vld,
  input  logic            out_rdy,
  output logic            taken,
  output logic [XLEN-1:0] tgt_addr,
  output logic [XLEN-1:0] link_pc,
  output logic            misalign,
  output logic            illegal,
  output logic            redir_vld,
  output logic [XLEN-1:0] redir_pc,
  input  logic            redir_ack,
  output logic [CNT_W-1:0] bj_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  typedef enum logic {RUN, REDIR} state_e;
  state_e state_q;

  logic            s1_vld_q, s1_uns_q, s1_rvc_q, s1_pt_q;
  logic [2:0]      s1_op_q;
  logic [XLEN-1:0] s1_pc_q, s1_a_q, s1_b_q, s1_off_q, s1_ptgt_q;

  logic            s2_vld_q, tk_q, mis_q, ill_q, misp_q;
  logic [XLEN-1:0] tgt_q, link_q, rpc_q;
  logic            rvld_q;
  logic [CNT_W-1:0] bj_q, mp_q;

  logic            stall, acc, out_hs, redir_go;
  logic            tk_d, mis_d, ill_d, misp_d, lt;
  logic [XLEN-1:0] tgt_d, link_d, sum_pc, sum_rs, inc;

  assign stall    = s2_vld_q & ~out_rdy;
  assign in_rdy   = ~rst & (state_q == RUN) & ~stall;
  assign acc      = in_vld & in_rdy;
  assign out_hs   = s2_vld_q & out_rdy;
  assign redir_go = (state_q == RUN) & out_hs & misp_q & ~flush;

  assign sum_pc = s1_pc_q + s1_off_q;
  assign sum_rs = s1_a_q + s1_off_q;
  assign tgt_d  = (s1_op_q == 3'd1) ? {sum_rs[XLEN-1:1], 1'b0} : sum_pc;
  assign inc    = (C_EXT != 0 && s1_rvc_q) ? XLEN'(2) : XLEN'(4);
  assign link_d = s1_pc_q + inc;
  assign ill_d  = s1_op_q[2] & s1_op_q[1];
  assign lt     = s1_uns_q ? (s1_a_q < s1_b_q)
                           : ($signed(s1_a_q) < $signed(s1_b_q));

  always_comb begin
    tk_d = 1'b0;
    unique case (s1_op_q)
      3'd0, 3'd1: tk_d = 1'b1;
      3'd2:       tk_d = (s1_a_q == s1_b_q);
      3'd3:       tk_d = (s1_a_q != s1_b_q);
      3'd4:       tk_d = lt;
      3'd5:       tk_d = ~lt;
      default:    tk_d = 1'b0;
    endcase
  end

  // A misaligned target traps instead of redirecting.
  assign mis_d  = (C_EXT != 0) ? (tk_d & tgt_d[0]) : (tk_d & |tgt_d[1:0]);
  assign misp_d = ((tk_d != s1_pt_q) | (tk_d & (tgt_d != s1_ptgt_q)))
                  & ~mis_d & ~ill_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      s1_vld_q  <= 1'b0;
      s1_uns_q  <= 1'b0;
      s1_rvc_q  <= 1'b0;
      s1_pt_q   <= 1'b0;
      s1_op_q   <= '0;
      s1_pc_q   <= '0;
      s1_a_q    <= '0;
      s1_b_q    <= '0;
      s1_off_q  <= '0;
      s1_ptgt_q <= '0;
      s2_vld_q  <= 1'b0;
      tk_q      <= 1'b0;
      mis_q     <= 1'b0;
      ill_q     <= 1'b0;
      misp_q    <= 1'b0;
      tgt_q     <= '0;
      link_q    <= '0;
      rpc_q     <= '0;
      rvld_q    <= 1'b0;
      bj_q      <= '0;
      mp_q      <= '0;
    end else begin
      if (out_hs & ~ill_q & ~&bj_q) bj_q <= bj_q + CNT_W'(1);
      if (redir_go & ~&mp_q) mp_q <= mp_q + CNT_W'(1);
      if (acc) begin
        s1_uns_q  <= unsigned_flg;
        s1_rvc_q  <= rvc;
        s1_pt_q   <= pred_taken;
        s1_op_q   <= op;
        s1_pc_q   <= pc;
        s1_a_q    <= s1;
        s1_b_q    <= s2;
        s1_off_q  <= offset;
        s1_ptgt_q <= pred_tgt;
      end
      if (~stall & s1_vld_q) begin
        tk_q   <= tk_d & ~ill_d;
        mis_q  <= mis_d;
        ill_q  <= ill_d;
        misp_q <= misp_d;
        tgt_q  <= tgt_d;
        link_q <= link_d;
      end
      if (flush) begin
        state_q  <= RUN;
        s1_vld_q <= 1'b0;
        s2_vld_q <= 1'b0;
        rvld_q   <= 1'b0;
      end else begin
        unique case (state_q)
          RUN: begin
            if (redir_go) begin
              // Younger S1 entry is on the wrong path.
              state_q  <= REDIR;
              rvld_q   <= 1'b1;
              rpc_q    <= tk_q ? tgt_q : link_q;
              s1_vld_q <= 1'b0;
              s2_vld_q <= 1'b0;
            end else if (~stall) begin
              s2_vld_q <= s1_vld_q;
              s1_vld_q <= acc;
            end
          end
          REDIR: begin
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
            if (redir_ack) begin
              state_q <= RUN;
              rvld_q  <= 1'b0;
            end
          end
          default: state_q <= RUN;
        endcase
      end
    end
  end

  assign out_vld     = s2_vld_q;
  assign taken       = tk_q;
  assign tgt_addr    = tgt_q;
  assign link_pc     = link_q;
  assign misalign    = mis_q;
  assign illegal     = ill_q;
  assign redir_vld   = rvld_q;
  assign redir_pc    = rpc_q;
  assign bj_cnt      = bj_q;
  assign mispred_cnt = mp_q;

endmodule

// File: tb/tb_rvi_bj_ex_pipe.sv
// Directed bench for rvi_bj_ex_pipe: default config plus a C_EXT=0,
// CNT_W=2 instance for alignment and counter saturation.
module tb_rvi_bj_ex_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_vld = 1'b0;
  logic        out_rdy = 1'b1;
  logic        redir_ack = 1'b0;
  logic [31:0] pc = '0, s1 = '0, s2 = '0, offset = '0, pred_tgt = '0;
  logic [2:0]  op = '0;
  logic        unsigned_flg = 1'b0, rvc = 1'b0, pred_taken = 1'b0;

  logic        in_rdy, out_vld, taken, misalign, illegal, redir_vld;
  logic [31:0] tgt_addr, link_pc, redir_pc;
  logic [15:0] bj_cnt, mispred_cnt;

  logic        b_in_vld = 1'b0, b_out_rdy = 1'b1;
  logic        b_flush = 1'b0, b_redir_ack = 1'b0;
  logic        b_in_rdy, b_out_vld, b_taken, b_misalign, b_illegal;
  logic        b_redir_vld;
  logic [31:0] b_tgt_addr, b_link_pc, b_redir_pc;
  logic [1:0]  b_bj_cnt, b_mispred_cnt;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  rvi_bj_ex_pipe u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_vld(in_vld), .in_rdy(in_rdy),
    .pc(pc), .s1(s1), .s2(s2), .offset(offset), .op(op),
    .unsigned_flg(unsigned_flg), .rvc(rvc),
    .pred_taken(pred_taken), .pred_tgt(pred_tgt),
    .out_vld(out_vld), .out_rdy(out_rdy),
    .taken(taken), .tgt_addr(tgt_addr), .link_pc(link_pc),
    .misalign(misalign), .illegal(illegal),
    .redir_vld(redir_vld), .redir_pc(redir_pc), .redir_ack(redir_ack),
    .bj_cnt(bj_cnt), .mispred_cnt(mispred_cnt)
  );

  rvi_bj_ex_pipe #(.RV64(0), .C_EXT(0), .CNT_W(2)) u_dut_b (
    .clk(clk), .rst(rst), .flush(b_flush),
    .in_vld(b_in_vld), .in_rdy(b_in_rdy),
    .pc(pc), .s1(s1), .s2(s2), .offset(offset), .op(op),
    .unsigned_flg(unsigned_flg), .rvc(rvc),
    .pred_taken(pred_taken), .pred_tgt(pred_tgt),
    .out_vld(b_out_vld), .out_rdy(b_out_rdy),
    .taken(b_taken), .tgt_addr(b_tgt_addr), .link_pc(b_link_pc),
    .misalign(b_misalign), .illegal(b_illegal),
    .redir_vld(b_redir_vld), .redir_pc(b_redir_pc),
    .redir_ack(b_redir_ack),
    .bj_cnt(b_bj_cnt), .mispred_cnt(b_mispred_cnt)
  );

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic req(input logic [2:0] o_, input logic [31:0] p_,
                     input logic [31:0] a_, input logic [31:0] b_,
                     input logic [31:0] off_, input logic u_,
                     input logic r_, input logic pt_,
                     input logic [31:0] ptg_);
    op = o_; pc = p_; s1 = a_; s2 = b_; offset = off_;
    unsigned_flg = u_; rvc = r_; pred_taken = pt_; pred_tgt = ptg_;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) tick();
    total++;
    if ({out_vld, redir_vld, taken, misalign, illegal} !== 5'b0) begin
      bad++;
      $display("FAIL rst_flags act=%b exp=00000",
               {out_vld, redir_vld, taken, misalign, illegal});
    end
    total++;
    if ((tgt_addr | link_pc | redir_pc) !== 32'h0) begin
      bad++;
      $display("FAIL rst_addr act=%h/%h/%h exp=0", tgt_addr, link_pc, redir_pc);
    end
    total++;
    if ({bj_cnt, mispred_cnt} !== 32'h0) begin
      bad++;
      $display("FAIL rst_cnt act=%h/%h exp=0", bj_cnt, mispred_cnt);
    end
    total++;
    if (in_rdy !== 1'b0) begin
      bad++;
      $display("FAIL rst_in_rdy act=%b exp=0", in_rdy);
    end
    rst = 1'b0;
    tick();
    total++;
    if (in_rdy !== 1'b1) begin
      bad++;
      $display("FAIL post_rst_in_rdy act=%b exp=1", in_rdy);
    end
  endtask

  task automatic test_beq;
    req(3'd2, 32'h100, 32'd5, 32'd5, 32'h20, 1'b0, 1'b0, 1'b1, 32'h120);
    in_vld = 1'b1;
    tick();
    in_vld = 1'b0;
    tick();
    total++;
    if ({out_vld, taken, illegal, misalign} !== 4'b1100) begin
      bad++;
      $display("FAIL beq_flags act=%b exp=1100",
               {out_vld, taken, illegal, misalign});
    end
    total++;
    if (tgt_addr !== 32'h120 || link_pc !== 32'h104) begin
      bad++;
      $display("FAIL beq_addr act=%h/%h exp=120/104", tgt_addr, link_pc);
    end
    tick();
    total++;
    if (out_vld !== 1'b0 || redir_vld !== 1'b0 || bj_cnt !== 16'd1
        || mispred_cnt !== 16'd0) begin
      bad++;
      $display("FAIL beq_retire act=%b/%b/%0d/%0d exp=0/0/1/0",
               out_vld, redir_vld, bj_cnt, mispred_cnt);
    end
  endtask

  task automatic test_blt;
    req(3'd4, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b0, 1'b0, 1'b1,
        32'h240);
    in_vld = 1'b1;
    tick();
    req(3'd4, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b1, 1'b0, 1'b0,
        32'h0);
    tick();
    in_vld = 1'b0;
    total++;
    if (out_vld !== 1'b1 || taken !== 1'b1) begin
      bad++;
      $display("FAIL blt_signed act=%b/%b exp=1/1", out_vld, taken);
    end
    tick();
    total++;
    if (out_vld !== 1'b1 || taken !== 1'b0) begin
      bad++;
      $display("FAIL blt_unsigned act=%b/%b exp=1/0", out_vld, taken);
    end
    tick();
    total++;
    if (redir_vld !== 1'b0 || bj_cnt !== 16'd3) begin
      bad++;
      $display("FAIL blt_retire act=%b/%0d exp=0/3", redir_vld, bj_cnt);
    end
  endtask

  task automatic test_jalr_redir;
    req(3'd1, 32'h300, 32'h2001, 32'h0, 32'h10, 1'b0, 1'b1, 1'b0, 32'h0);
    in_vld = 1'b1;
    tick();
    in_vld = 1'b0;
    tick();
    total++;
    if (taken !== 1'b1 || tgt_addr !== 32'h2010 || link_pc !== 32'h302) begin
      bad++;
      $display("FAIL jalr_res act=%b/%h/%h exp=1/2010/302",
               taken, tgt_addr, link_pc);
    end
    tick();
    total++;
    if (mispred_cnt !== 16'd1) begin
      bad++;
      $display("FAIL jalr_mpcnt act=%0d exp=1", mispred_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (redir_vld !== 1'b1 || redir_pc !== 32'h2010 || in_rdy !== 1'b0) begin
        bad++;
        $display("FAIL jalr_hold%0d act=%b/%h/%b exp=1/2010/0",
                 i, redir_vld, redir_pc, in_rdy);
      end
      if (i < 2) tick();
    end
    redir_ack = 1'b1;
    tick();
    redir_ack = 1'b0;
    total++;
    if (redir_vld !== 1'b0 || in_rdy !== 1'b1 || bj_cnt !== 16'd4) begin
      bad++;
      $display("FAIL jalr_ack act=%b/%b/%0d exp=0/1/4",
               redir_vld, in_rdy, bj_cnt);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_t [3];
    int idx = 0;
    int got = 0;
    exp_t[0] = 32'h410;
    exp_t[1] = 32'h424;
    exp_t[2] = 32'h438;
    for (int c = 0; c < 14; c++) begin
      out_rdy = (c >= 4);
      if (idx < 3) begin
        req(3'd2, 32'h400 + 32'(4 * idx), 32'd1, 32'd2,
            32'(16 * (idx + 1)), 1'b0, 1'b0, 1'b0, 32'h0);
        in_vld = 1'b1;
      end else begin
        in_vld = 1'b0;
      end
      #1;
      if (c == 3) begin
        total++;
        if (in_rdy !== 1'b0 || out_vld !== 1'b1) begin
          bad++;
          $display("FAIL b2b_stall act=%b/%b exp=0/1", in_rdy, out_vld);
        end
      end
      if (in_vld && in_rdy) idx++;
      if (out_vld && out_rdy) begin
        total++;
        if (got >= 3 || tgt_addr !== exp_t[got]) begin
          bad++;
          $display("FAIL b2b_order%0d act=%h exp=%h", got, tgt_addr,
                   (got < 3) ? exp_t[got] : 32'hx);
        end
        got++;
      end
      tick();
    end
    in_vld = 1'b0;
    out_rdy = 1'b1;
    total++;
    if (got !== 3 || idx !== 3) begin
      bad++;
      $display("FAIL b2b_count act=%0d/%0d exp=3/3", got, idx);
    end
  endtask

  task automatic test_flush;
    out_rdy = 1'b0;
    req(3'd2, 32'h600, 32'd1, 32'd1, 32'h8, 1'b0, 1'b0, 1'b1, 32'h608);
    in_vld = 1'b1;
    tick();
    req(3'd2, 32'h604, 32'd1, 32'd1, 32'h8, 1'b0, 1'b0, 1'b1, 32'h60C);
    tick();
    total++;
    if (out_vld !== 1'b1) begin
      bad++;
      $display("FAIL flush_pre act=%b exp=1", out_vld);
    end
    req(3'd2, 32'h608, 32'd1, 32'd1, 32'h8, 1'b0, 1'b0, 1'b1, 32'h610);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_vld = 1'b0;
    out_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (out_vld !== 1'b0) begin
        bad++;
        $display("FAIL flush_pipe%0d act=%b exp=0", i, out_vld);
      end
      tick();
    end
    req(3'd0, 32'h700, 32'h0, 32'h0, 32'h8, 1'b0, 1'b0, 1'b0, 32'h0);
    in_vld = 1'b1;
    tick();
    in_vld = 1'b0;
    tick();
    tick();
    total++;
    if (redir_vld !== 1'b1) begin
      bad++;
      $display("FAIL flush_redir_pre act=%b exp=1", redir_vld);
    end
    flush = 1'b1;
    redir_ack = 1'b1;
    tick();
    flush = 1'b0;
    redir_ack = 1'b0;
    total++;
    if (redir_vld !== 1'b0 || in_rdy !== 1'b1 || out_vld !== 1'b0) begin
      bad++;
      $display("FAIL flush_ack act=%b/%b/%b exp=0/1/0",
               redir_vld, in_rdy, out_vld);
    end
    total++;
    if (bj_cnt !== 16'd8 || mispred_cnt !== 16'd2) begin
      bad++;
      $display("FAIL flush_cnt act=%0d/%0d exp=8/2", bj_cnt, mispred_cnt);
    end
  endtask

  task automatic test_illegal;
    req(3'd6, 32'h800, 32'h0, 32'h0, 32'h10, 1'b0, 1'b0, 1'b1, 32'h810);
    in_vld = 1'b1;
    tick();
    in_vld = 1'b0;
    tick();
    total++;
    if ({out_vld, illegal, taken, misalign} !== 4'b1100) begin
      bad++;
      $display("FAIL ill_flags act=%b exp=1100",
               {out_vld, illegal, taken, misalign});
    end
    tick();
    total++;
    if (redir_vld !== 1'b0 || bj_cnt !== 16'd8 || mispred_cnt !== 16'd2) begin
      bad++;
      $display("FAIL ill_retire act=%b/%0d/%0d exp=0/8/2",
               redir_vld, bj_cnt, mispred_cnt);
    end
  endtask

  task automatic test_mid_reset;
    req(3'd0, 32'h900, 32'h0, 32'h0, 32'h4, 1'b0, 1'b0, 1'b0, 32'h0);
    in_vld = 1'b1;
    tick();
    in_vld = 1'b0;
    tick();
    tick();
    total++;
    if (redir_vld !== 1'b1) begin
      bad++;
      $display("FAIL mrst_redir_pre act=%b exp=1", redir_vld);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (redir_vld !== 1'b0 || in_rdy !== 1'b0 || mispred_cnt !== 16'd0) begin
      bad++;
      $display("FAIL mrst_redir act=%b/%b/%0d exp=0/0/0",
               redir_vld, in_rdy, mispred_cnt);
    end
    tick();
    rst = 1'b0;
    out_rdy = 1'b0;
    req(3'd0, 32'hA00, 32'h0, 32'h0, 32'h4, 1'b0, 1'b0, 1'b1, 32'hA04);
    in_vld = 1'b1;
    tick();
    in_vld = 1'b0;
    tick();
    total++;
    if (out_vld !== 1'b1) begin
      bad++;
      $display("FAIL mrst_pipe_pre act=%b exp=1", out_vld);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (out_vld !== 1'b0 || taken !== 1'b0 || tgt_addr !== 32'h0) begin
      bad++;
      $display("FAIL mrst_pipe act=%b/%b/%h exp=0/0/0",
               out_vld, taken, tgt_addr);
    end
    tick();
    rst = 1'b0;
    out_rdy = 1'b1;
    tick();
    total++;
    if (out_vld !== 1'b0 || bj_cnt !== 16'd0) begin
      bad++;
      $display("FAIL mrst_after act=%b/%0d exp=0/0", out_vld, bj_cnt);
    end
  endtask

  task automatic test_cext0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req(3'd0, 32'h0, 32'h0, 32'h0, 32'h6, 1'b0, 1'b1, 1'b0, 32'h0);
    b_in_vld = 1'b1;
    tick();
    req(3'd0, 32'h0, 32'h0, 32'h0, 32'h8, 1'b0, 1'b0, 1'b1, 32'h8);
    tick();
    total++;
    if ({b_out_vld, b_taken, b_misalign} !== 3'b111) begin
      bad++;
      $display("FAIL c0_flags act=%b exp=111",
               {b_out_vld, b_taken, b_misalign});
    end
    total++;
    if (b_tgt_addr !== 32'h6 || b_link_pc !== 32'h4) begin
      bad++;
      $display("FAIL c0_addr act=%h/%h exp=6/4", b_tgt_addr, b_link_pc);
    end
    tick();
    total++;
    if (b_redir_vld !== 1'b0 || b_bj_cnt !== 2'd1) begin
      bad++;
      $display("FAIL c0_first act=%b/%0d exp=0/1", b_redir_vld, b_bj_cnt);
    end
    tick();
    tick();
    b_in_vld = 1'b0;
    tick();
    tick();
    total++;
    if (b_bj_cnt !== 2'd3 || b_mispred_cnt !== 2'd0 || b_redir_vld !== 1'b0)
    begin
      bad++;
      $display("FAIL c0_sat act=%0d/%0d/%b exp=3/0/0",
               b_bj_cnt, b_mispred_cnt, b_redir_vld);
    end
  endtask

  initial begin
    test_reset();
    test_beq();
    test_blt();
    test_jalr_redir();
    test_back_to_back();
    test_flush();
    test_illegal();
    test_mid_reset();
    test_cext0();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
